// File: rtl/counter_unit.sv
// Free-running modulo counter with registered terminal-count pulse and a
// square wave that toggles on every wrap. All outputs come straight from flops.
module counter_unit #(
    parameter int unsigned     BW      = 8,
    parameter longint unsigned MOD_VAL = 64'd1 << BW,
    parameter int unsigned     DOWN    = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [BW-1:0] counter_val_o,
    output logic          tc_o,
    output logic          sq_o
);

    if (BW < 1 || BW > 32) begin : g_bad_bw
        $error("counter_unit: BW=%0d outside 1..32", BW);
    end
    if (MOD_VAL < 2 || MOD_VAL > (64'd1 << BW)) begin : g_bad_mod
        $error("counter_unit: MOD_VAL=%0d outside 2..2**BW", MOD_VAL);
    end
    if (DOWN > 1) begin : g_bad_dir
        $error("counter_unit: DOWN=%0d must be 0 or 1", DOWN);
    end

    localparam logic [BW-1:0] LAST_VAL = BW'(MOD_VAL - 64'd1);
    localparam logic [BW-1:0] RST_VAL  = (DOWN != 0) ? LAST_VAL : '0;
    // The terminal value is also the value the counter wraps away from.
    localparam logic [BW-1:0] TERM_VAL = (DOWN != 0) ? '0 : LAST_VAL;
    localparam logic          RST_TC   = (RST_VAL == TERM_VAL);

    logic [BW-1:0] cnt_q, cnt_d;
    logic          tc_q, tc_d;
    logic          sq_q, sq_d;
    logic          wrap;

    always_comb begin
        wrap  = (cnt_q == TERM_VAL);
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = RST_VAL;
        end else if (DOWN != 0) begin
            cnt_d = cnt_q - BW'(1);
        end else begin
            cnt_d = cnt_q + BW'(1);
        end
        tc_d = (cnt_d == TERM_VAL);
        sq_d = sq_q ^ wrap;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= RST_VAL;
            tc_q  <= RST_TC;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            sq_q  <= sq_d;
        end
    end

    assign counter_val_o = cnt_q;
    assign tc_o          = tc_q;
    assign sq_o          = sq_q;

endmodule

// File: tb/tb_counter_unit.sv
// Scoreboard bench for counter_unit: four parameterisations share one clock
// and reset; expected values derive from the number of edges since release.
module tb_counter_unit;

    logic clk_i = 1'b0;
    logic rst_i;

    logic [2:0] c0;  logic t0, s0;   // BW=3 up, mod 8
    logic [2:0] c1;  logic t1, s1;   // BW=3 up, mod 5
    logic [3:0] c2;  logic t2, s2;   // BW=4 down, mod 16
    logic [0:0] c3;  logic t3, s3;   // BW=1 up, mod 2

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk_i = ~clk_i;

    counter_unit #(.BW(3)) u0 (.clk_i(clk_i), .rst_i(rst_i), .counter_val_o(c0), .tc_o(t0), .sq_o(s0));
    counter_unit #(.BW(3), .MOD_VAL(5)) u1 (.clk_i(clk_i), .rst_i(rst_i), .counter_val_o(c1), .tc_o(t1), .sq_o(s1));
    counter_unit #(.BW(4), .DOWN(1)) u2 (.clk_i(clk_i), .rst_i(rst_i), .counter_val_o(c2), .tc_o(t2), .sq_o(s2));
    counter_unit #(.BW(1)) u3 (.clk_i(clk_i), .rst_i(rst_i), .counter_val_o(c3), .tc_o(t3), .sq_o(s3));

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int modv(input int inst);
        case (inst)
            0: return 8;
            1: return 5;
            2: return 16;
            default: return 2;
        endcase
    endfunction

    // k = rising edges since reset release (0 while in reset)
    task automatic push_exp(input int k);
        for (int i = 0; i < 4; i++) begin
            int m, cnt, term;
            m    = modv(i);
            cnt  = (i == 2) ? (m - 1 - (k % m)) : (k % m);
            term = (i == 2) ? 0 : m - 1;
            exp_q.push_back(cnt);
            exp_q.push_back(cnt == term ? 1 : 0);
            exp_q.push_back((k / m) % 2);
        end
    endtask

    task automatic pop_chk(input string phase);
        int obs[12];
        obs = '{int'(c0), int'(t0), int'(s0), int'(c1), int'(t1), int'(s1),
                int'(c2), int'(t2), int'(s2), int'(c3), int'(t3), int'(s3)};
        for (int i = 0; i < 12; i++) begin
            string nm;
            int e;
            if (exp_q.size() == 0) begin
                chk({phase, "_queue_empty"}, 0, 1);
                return;
            end
            e = exp_q.pop_front();
            case (i % 3)
                0: nm = $sformatf("%s_u%0d_cnt", phase, i / 3);
                1: nm = $sformatf("%s_u%0d_tc", phase, i / 3);
                default: nm = $sformatf("%s_u%0d_sq", phase, i / 3);
            endcase
            chk(nm, obs[i], e);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        #42;
        push_exp(0);
        pop_chk("reset");
        #8;
        rst_i = 1'b1;

        for (int k = 1; k <= 45; k++) begin
            push_exp(k);
            @(posedge clk_i);
            #1;
            pop_chk("run1");
        end

        // Mid-cycle async reset: BW=3 mod-8 unit sits at 5 with sq high here.
        #2;
        rst_i = 1'b0;
        #1;
        push_exp(0);
        pop_chk("async_rst");

        repeat (2) @(posedge clk_i);
        #1;
        push_exp(0);
        pop_chk("rst_hold");

        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            push_exp(k);
            @(posedge clk_i);
            #1;
            pop_chk("run2");
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
